// File: rtl/mips_reg_file_pkg.sv
// Shared constants for the MIPS register file and any control/datapath code
// that needs to name architectural registers.
package mips_reg_file_pkg;

  localparam int WIDTH    = 32;
  localparam int NREGS    = 32;
  localparam int ADDR_W   = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_RESET = 32'h0000_3FFC;

endpackage

// File: rtl/reg32.sv
// WIDTH-bit storage register with load enable and asynchronous active-low
// reset to a per-instance value.
//   clk   : clock
//   rst_n : async active-low reset, loads RST_VAL
//   i_en  : load enable
//   i_d   : data in
//   o_q   : register contents
module reg32 #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mips_reg_file.sv
// MIPS architectural register file: two combinational read ports, one
// clocked write port. Register 0 is hard-wired to zero; register 29 ($sp)
// resets to SP_RESET, all others to zero.
//   clk        : clock, writes on rising edge
//   rst_n      : async active-low reset
//   RegWrite   : write enable
//   write_reg  : write index
//   write_data : write value
//   read_reg1  : read port 1 index (rs) -> read_data1
//   read_reg2  : read port 2 index (rt) -> read_data2
module mips_reg_file #(
  parameter int               WIDTH    = mips_reg_file_pkg::WIDTH,
  parameter int               NREGS    = mips_reg_file_pkg::NREGS,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(mips_reg_file_pkg::SP_RESET)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 RegWrite,
  input  logic [mips_reg_file_pkg::ADDR_W-1:0] write_reg,
  input  logic [WIDTH-1:0]                     write_data,
  input  logic [mips_reg_file_pkg::ADDR_W-1:0] read_reg1,
  input  logic [mips_reg_file_pkg::ADDR_W-1:0] read_reg2,
  output logic [WIDTH-1:0]                     read_data1,
  output logic [WIDTH-1:0]                     read_data2
);

  import mips_reg_file_pkg::*;

  // Enables exist only for indices 1..NREGS-1, so index 0 can never be written.
  logic [NREGS-1:1] w_we;
  logic [WIDTH-1:0] w_q [NREGS];

  assign w_q[REG_ZERO] = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = (gi == REG_SP) ? SP_RESET : '0;

    assign w_we[gi] = RegWrite && (write_reg == ADDR_W'(gi));

    reg32 #(
      .WIDTH   (WIDTH),
      .RST_VAL (RV)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_we[gi]),
      .i_d   (write_data),
      .o_q   (w_q[gi])
    );
  end

  // Reads see stored state only; no write-data bypass, which keeps the
  // ALU -> write-back -> read path free of a combinational loop.
  assign read_data1 = w_q[read_reg1];
  assign read_data2 = w_q[read_reg2];

endmodule
